hack_alu_seq: RTL and testbench



---
 rtl/hack_alu_pkg.sv | 31 +++
 rtl/hack_alu_comb.sv | 79 +++++++
 rtl/hack_alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_hack_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared types for the registered Hack ALU: mode and state encodings plus
// the captured command control word.
package hack_alu_pkg;

    typedef enum logic [1:0] {
        MODE_HACK = 2'd0,
        MODE_MUL  = 2'd1,
        MODE_SHL  = 2'd2,
        MODE_ASR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic  zx;
        logic  nx;
        logic  zy;
        logic  ny;
        logic  f;
        logic  no;
        mode_e mode;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0,
                                     f: 1'b0, no: 1'b0, mode: MODE_HACK};

endpackage

// File: rtl/hack_alu_comb.sv
// Combinational Hack ALU core: operand preprocessing, and/add with carry and
// overflow, barrel shifts, and the final invert/zero/negative stage.
module hack_alu_comb
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_zx,
    input  logic             i_nx,
    input  logic             i_zy,
    input  logic             i_ny,
    input  logic             i_f,
    input  logic             i_no,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_px,
    output logic [WIDTH-1:0] o_py,
    output logic [WIDTH-1:0] o_out,
    output logic             o_zr,
    output logic             o_ng,
    output logic             o_cout,
    output logic             o_ov
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_px0;
    logic [WIDTH-1:0] w_py0;
    logic [WIDTH-1:0] w_px;
    logic [WIDTH-1:0] w_py;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_out;
    logic             w_cout;
    logic             w_ov;

    assign w_px0 = i_zx ? {WIDTH{1'b0}} : i_x;
    assign w_px  = i_nx ? ~w_px0 : w_px0;
    assign w_py0 = i_zy ? {WIDTH{1'b0}} : i_y;
    assign w_py  = i_ny ? ~w_py0 : w_py0;
    assign w_sum = {1'b0, w_px} + {1'b0, w_py};
    assign w_sh  = w_py[SHW-1:0];

    // Mode select; carry and overflow only carry meaning for the Hack add.
    always_comb begin
        w_r    = {WIDTH{1'b0}};
        w_cout = 1'b0;
        w_ov   = 1'b0;
        case (mode_e'(i_mode))
            MODE_HACK: begin
                if (i_f) begin
                    w_r    = w_sum[WIDTH-1:0];
                    w_cout = w_sum[WIDTH];
                    w_ov   = (w_px[WIDTH-1] == w_py[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != w_px[WIDTH-1]);
                end else begin
                    w_r = w_px & w_py;
                end
            end
            MODE_MUL: w_r = i_acc;
            MODE_SHL: w_r = w_px << w_sh;
            MODE_ASR: w_r = $unsigned($signed(w_px) >>> w_sh);
            default:  w_r = {WIDTH{1'b0}};
        endcase
    end

    assign w_out  = i_no ? ~w_r : w_r;
    assign o_px   = w_px;
    assign o_py   = w_py;
    assign o_out  = w_out;
    assign o_zr   = (w_out == {WIDTH{1'b0}});
    assign o_ng   = w_out[WIDTH-1];
    assign o_cout = w_cout;
    assign o_ov   = w_ov;

endmodule

// File: rtl/hack_alu_seq.sv
// Registered Hack ALU with valid/ready handshakes, an iterative shift-add
// multiplier, and result hold under back-pressure.
module hack_alu_seq
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cout,
    output logic             ov
);

    localparam int SHW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    ctrl_t            r_ctrl;
    ctrl_t            w_in_ctrl;
    ctrl_t            w_sel_ctrl;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;
    logic             r_cout;
    logic             r_ov;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_px;
    logic [WIDTH-1:0] w_py;
    logic [WIDTH-1:0] w_res;
    logic             w_zr;
    logic             w_ng;
    logic             w_cout;
    logic             w_ov;
    logic             w_hs;
    logic             w_last;

    assign w_in_ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no,
                         mode: mode_e'(mode)};
    // While multiplying, the shared core finishes with the captured command.
    assign w_sel_ctrl = (r_state == BUSY) ? r_ctrl : w_in_ctrl;
    assign w_hs       = in_valid && in_ready;
    assign w_last     = (r_state == BUSY) && (r_cnt == SHW'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

    hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_x    (x),
        .i_y    (y),
        .i_zx   (w_sel_ctrl.zx),
        .i_nx   (w_sel_ctrl.nx),
        .i_zy   (w_sel_ctrl.zy),
        .i_ny   (w_sel_ctrl.ny),
        .i_f    (w_sel_ctrl.f),
        .i_no   (w_sel_ctrl.no),
        .i_mode (w_sel_ctrl.mode),
        .i_acc  (w_acc_next),
        .o_px   (w_px),
        .o_py   (w_py),
        .o_out  (w_res),
        .o_zr   (w_zr),
        .o_ng   (w_ng),
        .o_cout (w_cout),
        .o_ov   (w_ov)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; HOLD with a waiting command dispatches like IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_next = (w_in_ctrl.mode == MODE_MUL) ? BUSY : HOLD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = BUSY;
                end
            end
            HOLD: begin
                if (w_hs) begin
                    w_state_next = (w_in_ctrl.mode == MODE_MUL) ? BUSY : HOLD;
                end else if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            BUSY: in_ready = 1'b0;
            HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Command capture, multiplier iteration and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= CTRL_RESET;
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {SHW{1'b0}};
            r_out    <= {WIDTH{1'b0}};
            r_zr     <= 1'b0;
            r_ng     <= 1'b0;
            r_cout   <= 1'b0;
            r_ov     <= 1'b0;
        end else if (w_hs) begin
            r_ctrl <= w_in_ctrl;
            if (w_in_ctrl.mode == MODE_MUL) begin
                r_acc    <= {WIDTH{1'b0}};
                r_mcand  <= w_px;
                r_mplier <= w_py;
                r_cnt    <= {SHW{1'b0}};
            end else begin
                r_out  <= w_res;
                r_zr   <= w_zr;
                r_ng   <= w_ng;
                r_cout <= w_cout;
                r_ov   <= w_ov;
            end
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
            if (w_last) begin
                r_out  <= w_res;
                r_zr   <= w_zr;
                r_ng   <= w_ng;
                r_cout <= w_cout;
                r_ov   <= w_ov;
            end else begin
                r_out <= r_out;
            end
        end else begin
            r_out <= r_out;
        end
    end

    assign out  = r_out;
    assign zr   = r_zr;
    assign ng   = r_ng;
    assign cout = r_cout;
    assign ov   = r_ov;

endmodule

// File: tb/tb_hack_alu_seq.sv
// Directed and randomised bench for hack_alu_seq (WIDTH=16) with a
// queue-based scoreboard fed at each handshake and drained at each transfer.
module tb_hack_alu_seq;

    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic        cout;
        logic        ov;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        zx, nx, zy, ny, f, no;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr, ng, cout, ov;

    res_t sb[$];
    int   n_tests;
    int   n_fail;
    int   n_push;
    int   n_pop;
    logic hs_seen;

    always #5 clk = ~clk;

    hack_alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .cout      (cout),
        .ov        (ov)
    );

    // Reference behaviour built from plain operators (product via '*').
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [5:0] c, input logic [1:0] m);
        logic [15:0] px, py, r;
        logic [16:0] s;
        res_t        e;
        px = c[5] ? 16'h0000 : a;
        if (c[4]) px = ~px;
        py = c[3] ? 16'h0000 : b;
        if (c[2]) py = ~py;
        e.cout = 1'b0;
        e.ov   = 1'b0;
        r      = 16'h0000;
        case (m)
            2'd0: begin
                if (c[1]) begin
                    s      = {1'b0, px} + {1'b0, py};
                    r      = s[15:0];
                    e.cout = s[16];
                    e.ov   = (px[15] == py[15]) && (r[15] != px[15]);
                end else begin
                    r = px & py;
                end
            end
            2'd1:    r = px * py;
            2'd2:    r = px << py[3:0];
            default: r = $unsigned($signed(px) >>> py[3:0]);
        endcase
        if (c[0]) r = ~r;
        e.out = r;
        e.zr  = (r == 16'h0000);
        e.ng  = r[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard bookkeeping at the negedge, return #1 after posedge.
    task automatic tick();
        res_t g;
        res_t e;
        @(negedge clk);
        hs_seen = 1'b0;
        if (!reset && out_valid && out_ready) begin
            g.out = out; g.zr = zr; g.ng = ng; g.cout = cout; g.ov = ov;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", 32'(g), 32'(e));
                n_pop++;
            end
        end
        if (!reset && in_valid && in_ready) begin
            sb.push_back(model(x, y, {zx, nx, zy, ny, f, no}, mode));
            n_push++;
            hs_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c,
                        input logic [1:0] m, output int waited);
        {zx, nx, zy, ny, f, no} = c;
        x = a; y = b; mode = m; in_valid = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!hs_seen && waited < 60);
        if (!hs_seen) chk("hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] o, input logic z,
                              input logic n, input logic c, input logic v);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(o));
        chk({tag, "_zr"}, 32'(zr), 32'(z));
        chk({tag, "_ng"}, 32'(ng), 32'(n));
        chk({tag, "_cout"}, 32'(cout), 32'(c));
        chk({tag, "_ov"}, 32'(ov), 32'(v));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        n_tests = 0; n_fail = 0; n_push = 0; n_pop = 0; hs_seen = 1'b0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = 16'h0000; y = 16'h0000; mode = 2'd0;
        {zx, nx, zy, ny, f, no} = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flags", 32'({zr, ng, cout, ov}), 32'd0);

        // Hack add, inverted add, signed overflow, carry-out.
        send(16'd5, 16'd3, 6'b000010, 2'd0, w);
        expect_out("add", 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'd5, 16'd3, 6'b000011, 2'd0, w);
        expect_out("add_no", 16'hFFF7, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 6'b000010, 2'd0, w);
        expect_out("add_ov", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0001, 6'b000010, 2'd0, w);
        expect_out("add_cout", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();

        // Multiply: busy for 16 edges after the handshake, valid after the 16th.
        send(16'd300, 16'd300, 6'b000000, 2'd1, w);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("busy_out_valid", 32'(out_valid), 32'd0);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        expect_out("mul", 16'h5F90, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        send(16'd1234, 16'd77, 6'b100000, 2'd1, w);
        in_valid = 1'b0;
        wait_valid("mul_zx");
        expect_out("mul_zx", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Shifts.
        send(16'h8000, 16'd4, 6'b000000, 2'd3, w);
        expect_out("asr", 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h0001, 16'd15, 6'b000000, 2'd2, w);
        expect_out("shl15", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'd0, 6'b000000, 2'd2, w);
        expect_out("shl0", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();

        // Back-pressure: result held for 5 cycles, then 4 commands stream through.
        out_ready = 1'b0;
        send(16'h1234, 16'h0101, 6'b000010, 2'd0, w);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out", 32'(out), 32'h1335);
            chk("bp_flags", 32'({zr, ng, cout, ov}), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(16'h0100 + 16'(i), 16'h0F00 - 16'(i * 3), 6'b000010, 2'd0, w);
            chk("stream_rate", 32'(w), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_drain", 32'(sb.size()), 32'd0);
        chk("stream_count", 32'(n_pop), 32'(n_push));

        // Reset during BUSY cycle 5 discards the multiply.
        send(16'd300, 16'd300, 6'b000000, 2'd1, w);
        in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("rst_busy_valid", 32'(out_valid), 32'd0);
        chk("rst_busy_out", 32'(out), 32'd0);
        chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        sb.delete();
        send(16'd2, 16'd2, 6'b000010, 2'd0, w);
        expect_out("post_rst_add", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();

        // Random mix of all modes and control bits through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom_range(0, 3)), w);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        chk("rand_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
